// File: rtl/fixedpoint_pkg.sv
// Shared types and constants for the signed fixed-point MAC path.
package fixedpoint_pkg;

  // Product format from the multiplier: signed Q7.1
  localparam int DATA_W    = 8;
  localparam int FRAC_BITS = 1;

  // Default accumulator width: signed Q11.1
  localparam int ACC_W     = 12;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [DATA_W-1:0] SAT_MAX = 8'h7F;
  localparam logic [DATA_W-1:0] SAT_MIN = 8'h80;

endpackage

// File: rtl/fixedpoint_sat.sv
// Combinational saturation of a wide signed value to the product width.
// Also usable by the multiplier's output stage.
module fixedpoint_sat
  import fixedpoint_pkg::*;
#(
  parameter int IN_W = ACC_W
) (
  input  logic [IN_W-1:0]   in_val,
  output logic [DATA_W-1:0] sat_val,
  output logic              ovf
);

  // The value fits in DATA_W bits exactly when every bit from the target
  // sign position upward is a copy of the sign.
  logic [IN_W-DATA_W:0] upper;

  assign upper = in_val[IN_W-1:DATA_W-1];

  // Clamp to the nearest representable extreme when the upper bits disagree.
  always_comb begin
    ovf     = !((&upper) || (~|upper));
    sat_val = in_val[DATA_W-1:0];
    if (ovf) begin
      sat_val = in_val[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/fixedpoint_s_acc.sv
// Frame accumulator for signed Q7.1 products.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_ACCUM | accepting products, summing into acc, counting the frame
//   ST_HOLD  | frame result presented on out_*, waiting for out_ready
//
// The accumulator is sized so a full frame cannot wrap as long as
// FRAME_LEN <= 2**(ACC_W-DATA_W).
module fixedpoint_s_acc #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_sat,
  output logic              out_ovf
);

  fixedpoint_pkg::state_t state, state_nxt;

  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  sum_nxt;
  logic [DATA_W-1:0] sat_nxt;
  logic              ovf_nxt;
  logic              accept;
  logic              last_beat;

  assign sum_nxt   = acc + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(FRAME_LEN - 1));

  // Saturate the running sum including the current beat; only latched on
  // the last beat of a frame.
  fixedpoint_sat #(
    .IN_W (ACC_W)
  ) u_sat (
    .in_val  (sum_nxt),
    .sat_val (sat_nxt),
    .ovf     (ovf_nxt)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= fixedpoint_pkg::ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; clr in ACCUM discards the beat.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      fixedpoint_pkg::ST_ACCUM: begin
        in_ready = 1'b1;
        if (accept && !clr && last_beat) begin
          state_nxt = fixedpoint_pkg::ST_HOLD;
        end
      end
      fixedpoint_pkg::ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = fixedpoint_pkg::ST_ACCUM;
        end
      end
      default: state_nxt = fixedpoint_pkg::ST_ACCUM;
    endcase
  end

  // Accumulator, frame counter and result registers. Results only change
  // on the closing beat, so they stay stable throughout HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_sat <= '0;
      out_ovf <= 1'b0;
    end else if (state == fixedpoint_pkg::ST_ACCUM) begin
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        if (last_beat) begin
          acc     <= '0;
          cnt     <= '0;
          out_sum <= sum_nxt;
          out_sat <= sat_nxt;
          out_ovf <= ovf_nxt;
        end else begin
          acc <= sum_nxt;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/fixedpoint_s_acc.md
Name: fixedpoint_s_acc

Overview:
Downstream consumer of the signed fixed-point multiplier. It takes the multiplier's 8-bit signed Q7.1 products (two's complement, LSB = 0.5) over a valid/ready stream and sums a fixed-length frame of them. It presents the full-width frame sum, an 8-bit saturated Q7.1 sum and an overflow flag on a valid/ready output. This forms the accumulate half of the fixed-point MAC path.

Parameters:
DATA_W, 8, input product width, signed Q7.1
ACC_W, 12, accumulator width, signed Q11.1; legal only while FRAME_LEN <= 2**(ACC_W-DATA_W)
FRAME_LEN, 4, products summed per frame, range 1..16
CNT_W, 4, frame counter width, must hold FRAME_LEN-1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
clr  in  1  synchronous frame abort: drop partial sum and count
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  DATA_W  signed Q7.1 product from multiplier
out_valid  out  1  frame result valid
out_ready  in  1  consumer takes result
out_sum  out  ACC_W  full frame sum, signed Q11.1
out_sat  out  DATA_W  out_sum saturated to signed 8 bits, Q7.1
out_ovf  out  1  1 when out_sat != out_sum (saturation applied)

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). The polarity and synchronicity are fixed.
- Reset (rst_n=0 at a clk edge): state=ACCUM, acc=0, cnt=0, out_valid=0, out_sum=0, out_sat=0, out_ovf=0. in_ready=1 from the first cycle after reset. Reset mid-frame or in HOLD discards everything.
- State ACCUM: in_ready=1, out_valid=0.
  - On accept (in_valid&&in_ready): acc <= acc + sign-extend(in_data) to ACC_W; cnt <= cnt+1.
  - On the accept where cnt==FRAME_LEN-1:
    - out_sum <= acc + sext(in_data);
    - out_sat/out_ovf are computed from that same value;
    - acc, cnt <= 0; state <= HOLD.
  - Latency: out_valid rises on the cycle after the last accept.
- State HOLD: in_ready=0, out_valid=1, and out_sum/out_sat/out_ovf stay stable.
  - When out_ready=1: state <= ACCUM, out_valid drops on the next cycle, and in_ready rises on that same cycle.
  - out_ready=0 holds indefinitely (backpressure); no inputs are accepted.
- Saturation:
  - out_sum > 127 -> out_sat=8'h7F, ovf=1.
  - out_sum < -128 -> out_sat=8'h80, ovf=1.
  - Otherwise out_sat=out_sum[7:0], ovf=0.
- acc never wraps, given the parameter constraint.
- clr:
  - In ACCUM, clr sets acc=0 and cnt=0. clr wins over a simultaneous accept, which is discarded (in_ready stays 1, so the producer sees the item taken and dropped).
  - In HOLD, clr is ignored; the result must still be drained.
- in_valid without in_ready: no state change; the producer holds its data.
- FRAME_LEN=1: every accept goes straight to HOLD.

Decomposition:
- Package fixedpoint_pkg:
  - DATA_W=8 and FRAC_BITS=1 (product format), ACC_W default.
  - State enum {ST_ACCUM, ST_HOLD}.
  - Constants SAT_MAX=8'h7F and SAT_MIN=8'h80.
- One combinational sub-module, fixedpoint_sat: ACC_W in -> DATA_W out plus ovf flag. It is reusable by the multiplier's output stage. The FSM, counter and accumulator stay in fixedpoint_s_acc.

Test Plan:
- Nominal: FRAME_LEN=4, out_ready=1, feed 02, f7, f8, 02 (1, -4.5, -4, 1) -> one cycle after the 4th accept, out_valid=1, out_sum=12'hFF3 (-6.5), out_sat=8'hF3, out_ovf=0; in_ready=1 again two cycles after the 4th accept.
- Positive saturation: 7F x4 -> out_sum=12'h1FC, out_sat=8'h7F, out_ovf=1. Negative: 80 x4 -> out_sum=12'hE00, out_sat=8'h80, out_ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid with in_valid=1 and data 10 -> in_ready=0 and outputs stable all 3 cycles. Assert out_ready -> the next frame starts clean; 10 x4 then gives out_sum=12'h040, out_sat=8'h40.
- Bubbles: in_valid toggled 1,0,0,1,0,1,1 with data 02 each -> only the 4 valid beats count; out_sum=12'h008.
- clr: feed 7F, 7F, then clr=1 together with in_valid=1 (data 7F), then 01 x4 -> clr'd beat dropped; out_sum=12'h004, ovf=0.
- Reset mid-frame: feed 2 beats of 20, rst_n=0 for 1 cycle -> all outputs 0, out_valid=0. Then 01, 02, 03, 04 -> out_sum=12'h00A.
